// File: rtl/ex_mdu_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states
// and the result bundle handed from the arithmetic block to the HI/LO owner.
package ex_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // wr=0 marks a result that must not reach HI/LO (divide by zero)
  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit MULT/MULTU/DIV/DIVU result. Signed divide works on
// magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
module mdu_arith
  import ex_mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output mdu_res_t    res
);

  logic [63:0] prod_s, prod_u;
  logic        sdiv, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_den, q_mag, r_mag;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  assign sdiv  = (op == MDU_DIV);
  assign a_neg = sdiv & a[31];
  assign b_neg = sdiv & b[31];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  // keep the divider defined on a zero divisor; the result is discarded anyway
  assign b_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / b_den;
  assign r_mag = a_mag % b_den;

  always_comb begin
    res = '0;
    case (op)
      MDU_MULT:  res = '{wr: 1'b1, hi: prod_s[63:32], lo: prod_s[31:0]};
      MDU_MULTU: res = '{wr: 1'b1, hi: prod_u[63:32], lo: prod_u[31:0]};
      MDU_DIV, MDU_DIVU: begin
        res.wr = (b != 32'd0);
        res.hi = a_neg ? -r_mag : r_mag;
        res.lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multi-cycle multiply/divide unit owning HI/LO. The result is computed
// at the start edge and held in a pending register until the busy window ends.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  mdu_state_e    state, state_n;
  logic [CW-1:0] cnt;
  mdu_res_t      pend, arith_res;
  logic          md_op, accept, done;

  assign md_op     = is_muldiv(mdu_op);
  assign accept    = (state == ST_IDLE) && start && md_op;
  assign done      = (state == ST_RUN) && (cnt == CW'(1));
  assign stall_req = (start & md_op) | busy;

  mdu_arith u_arith (
    .op  (mdu_op),
    .a   (rs_data),
    .b   (rt_data),
    .res (arith_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = ST_RUN;
      ST_RUN:  if (done)   state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // starts seen while running are dropped: the hazard unit should never issue them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      pend <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (state == ST_IDLE) begin
      if (accept) begin
        pend <= arith_res;
        cnt  <= is_div(mdu_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        busy <= 1'b1;
      end else if (start && (mdu_op == MDU_MTHI)) begin
        hi <= rs_data;
      end else if (start && (mdu_op == MDU_MTLO)) begin
        lo <= rs_data;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (done) begin
        busy <= 1'b0;
        if (pend.wr) begin
          hi <= pend.hi;
          lo <= pend.lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: the driver pushes model results, a negedge monitor
// pops on each commit (busy fall or accepted MTHI/MTLO) and compares.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  ex_mdu #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  int          nvec = 0, nmis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model: plain 64-bit arithmetic from the instruction definitions
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output bit push);
    int     ia, ib;
    longint sa, sb, qq, rr;
    logic [63:0] p;
    ia = a; ib = b; sa = ia; sb = ib;
    push = 1'b1; cyc = 0;
    case (op)
      MDU_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; cyc = NM; end
      MDU_MULTU: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; cyc = NM; end
      MDU_DIV: begin
        cyc = ND;
        if (b != 0) begin qq = sa / sb; rr = sa % sb; m_lo = qq[31:0]; m_hi = rr[31:0]; end
      end
      MDU_DIVU: begin
        cyc = ND;
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      end
      MDU_MTHI: m_hi = a;
      MDU_MTLO: m_lo = a;
      default:  push = 1'b0;
    endcase
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    int cyc;
    bit push;
    if (track) begin
      model(op, a, b, cyc, push);
      if (push) q.push_back('{$sformatf("op%0d %h,%h", op, a, b), m_hi, m_lo, cyc});
    end
    start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
    step();
    start = 1'b0; rs_data = $urandom; rt_data = $urandom; mdu_op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (!busy && q.size() == 0) begin ok = 1'b1; break; end
    end
    nvec++;
    if (!ok) begin
      nmis++;
      $display("FAIL wait_idle: busy=%0b pending=%0d, required idle and drained", busy, q.size());
    end
  endtask

  // monitor
  logic       s_start = 1'b0, s_busy = 1'b0, stall_err = 1'b0;
  logic [2:0] s_op = 3'd0;
  int         run_len = 0;
  exp_t       e;

  always @(negedge clk) begin
    if (!reset) begin
      s_start = 1'b0; s_busy = 1'b0; run_len = 0; stall_err = 1'b0;
    end else begin
      if ((s_busy && !busy) ||
          (s_start && !s_busy && (s_op == MDU_MTHI || s_op == MDU_MTLO))) begin
        if (q.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL unexpected_commit: hi=%h lo=%h with empty scoreboard", hi, lo);
        end else begin
          e = q.pop_front();
          chk({e.name, " hi"}, hi, e.hi);
          chk({e.name, " lo"}, lo, e.lo);
          chk({e.name, " busy_cycles"}, run_len, e.cyc);
          chk({e.name, " stall_req"}, stall_err, 1'b0);
        end
        run_len = 0; stall_err = 1'b0;
      end
      if (busy) run_len++;
      if (stall_req !== (busy || (start && mdu_op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU})))
        stall_err = 1'b1;
      s_start = start; s_op = mdu_op; s_busy = busy;
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bit          hit;

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset stall_req", stall_req, 0);
    reset = 1'b1;
    step();

    issue(MDU_MULT,  32'hFFFFFFFE, 32'd3, 1); wait_idle();
    step(); issue(MDU_MULTU, 32'hFFFFFFFE, 32'd3, 1); wait_idle();
    step(); issue(MDU_DIV,  32'hFFFFFFF9, 32'd2, 1); wait_idle();
    step(); issue(MDU_DIVU, 32'd100, 32'd7, 1); wait_idle();

    step(); issue(MDU_MTHI, 32'h1234, 32'd0, 1); wait_idle();
    step(); issue(MDU_MTLO, 32'h5678, 32'd0, 1); wait_idle();
    step(); issue(MDU_DIV,  32'd55, 32'd0, 1); wait_idle();
    chk("div0 hi", hi, 32'h1234);
    chk("div0 lo", lo, 32'h5678);

    // MTLO arriving during busy cycle 2 must be dropped
    step(); issue(MDU_MULT, 32'd6, 32'd7, 1);
    step(); issue(MDU_MTLO, 32'hAA, 32'd0, 0);
    wait_idle();
    chk("mult_ignore lo", lo, 32'd42);
    chk("mult_ignore hi", hi, 32'd0);

    // overflow divide, then MULT issued in the first cycle busy reads low
    step(); issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1);
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!busy) begin hit = 1'b1; break; end
      step();
    end
    nvec++;
    if (!hit) begin nmis++; $display("FAIL b2b_fall: busy stuck high, required low"); end
    issue(MDU_MULT, 32'h00010003, 32'hFFFF0002, 1);
    wait_idle();

    // unknown op codes change nothing
    step(); issue(3'd7, 32'hDEAD, 32'hBEEF, 1); wait_idle();
    step(); issue(MDU_NONE, 32'hDEAD, 32'hBEEF, 1); wait_idle();
    chk("unknown hi", hi, m_hi);
    chk("unknown lo", lo, m_lo);

    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($signed($urandom_range(0, 40)) - 20); b = 32'($signed($urandom_range(0, 40)) - 20); end
        2: begin a = 32'h80000000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'd1; end
        default: begin a = $urandom; b = 32'd0; end
      endcase
      step(); issue(op, a, b, 1);
      if (is_muldiv(op) && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) step();
        issue(3'($urandom_range(1, 6)), $urandom, $urandom, 0);
      end
      wait_idle();
      chk("rand hi", hi, m_hi);
      chk("rand lo", lo, m_lo);
    end

    // reset two cycles into a DIV: immediate clear, no late commit
    step(); issue(MDU_DIV, 32'd100, 32'd7, 0);
    step();
    reset = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst hi", hi, 0);
    chk("midrst lo", lo, 0);
    m_hi = '0; m_lo = '0;
    step();
    reset = 1'b1;
    repeat (15) step();
    chk("postrst busy", busy, 0);
    chk("postrst hi", hi, 0);
    chk("postrst lo", lo, 0);

    step(); issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1); wait_idle();
    chk("scoreboard drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline, directly downstream of the ID/EX pipeline register. Consumes the Rs/Rt operand values and decoded MDU op from ID/EX, runs MULT/MULTU/DIV/DIVU over a fixed number of cycles, and owns the architectural HI/LO registers. Exposes busy/stall information to the hazard unit so MDU-dependent instructions are held in ID.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
start  in  1  EX-stage instruction is an MDU op this cycle (one-cycle pulse from controller)
mdu_op  in  3  operation code (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO)
rs_data  in  32  forwarded Rs operand (dividend / multiplicand / MTHI-MTLO source)
rt_data  in  32  forwarded Rt operand (divisor / multiplier)
busy  out  1  registered; high while a multi-cycle op is in progress
stall_req  out  1  combinational: start & (op is MULT/MULTU/DIV/DIVU), or busy
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (reset==0, async): busy=0, hi=0, lo=0, state=IDLE, counter=0, pending results cleared. Reset mid-operation aborts the op; no commit.
- States: IDLE, RUN.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU: at that edge compute 64-bit result into pending_hi/pending_lo, load counter with MULT_CYCLES or DIV_CYCLES, busy<=1, go RUN.
- RUN: counter decrements each edge; on the edge where counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0, go IDLE. Start at cycle t => busy high cycles t+1..t+N; new HI/LO and busy=0 both visible in cycle t+N+1.
- MTHI/MTLO in IDLE: single cycle, no busy; hi (or lo) <= rs_data at the start edge, visible t+1.
- start while RUN (any op): ignored entirely; hazard unit stalls via stall_req, so this is a protocol error, not a queued request.
- start with unknown mdu_op: no effect.
- MULT: signed 32x32 -> 64; hi=[63:32], lo=[31:0]. MULTU: unsigned.
- DIV: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend. DIVU: unsigned.
- Divisor==0 (DIV/DIVU): op still runs full DIV_CYCLES with busy; hi/lo left unchanged at completion.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
- hi/lo readable every cycle (MFHI/MFLO read value directly); they never change except at a commit or MTHI/MTLO edge.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

Decomposition:
- Shared package/header: MDU op encodings (MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6), state encodings.
- Optional sub-module mdu_arith: purely combinational 64-bit result computation (mult/div, signedness, divide-by-zero and overflow cases); ex_mdu holds FSM, counter, HI/LO.

Test Plan:
- reset low mid-run (cycle t+2 of DIV with 100/7) -> busy=0, hi=0, lo=0 immediately; after release, no late commit.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIV with rt=0 after MTHI 0x1234 / MTLO 0x5678 -> busy 10 cycles, hi=0x1234, lo=0x5678 unchanged.
- MULT 6x7 then start=1 MTLO 0xAA at busy cycle 2 -> MTLO ignored; final lo=42, hi=0; stall_req high throughout busy.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; back-to-back MULT started the cycle after busy falls is accepted.
